// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the memory scoreboard: transfer type
// encodings, protection bit positions and the per-slot state type.
package ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE = 2'b00,
      HTRANS_BUSY = 2'b01,
      HTRANS_NSEQ = 2'b10,
      HTRANS_SEQ  = 2'b11
   } htrans_t;

   localparam int HPROT_BUFFERABLE_BIT = 2;
   localparam int HPROT_CACHEABLE_BIT  = 3;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_VALID = 1'b1
   } slot_state_t;

   // Only cacheable+bufferable traffic is shadowed by the scoreboard.
   function automatic logic prot_tracked(input logic [3:0] prot);
      return prot[HPROT_CACHEABLE_BIT] && prot[HPROT_BUFFERABLE_BIT];
   endfunction

endpackage

// File: rtl/ahbl_mem_scoreboard_if.sv
// AHB-Lite bus bundle. Handshake: an address phase with htrans[1]=1 is
// accepted on the rising edge where hready=1; its data phase then completes
// on the next rising edge where hready=1, and hresp on that edge gives the
// outcome (a two-cycle ERROR shows hresp=1 with hready=0 first). While an
// accepted request is stalled (hready=0) the master holds its address phase.
interface ahbl_mem_scoreboard_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              hready;
   logic              hresp;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic [W_ADDR-1:0] haddr;
   logic [W_DATA-1:0] hwdata;
   logic [W_DATA-1:0] hrdata;

   modport master (
      output htrans, hwrite, hsize, hburst, hprot, haddr, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  htrans, hwrite, hsize, hburst, hprot, haddr, hwdata,
      output hready, hresp, hrdata
   );

   // Passive tap used by the scoreboard.
   modport monitor (
      input htrans, hwrite, hsize, hburst, hprot, haddr, hwdata,
            hready, hresp, hrdata
   );
endinterface

// File: rtl/ahbl_scoreboard_slot.sv
// One tracked byte: decides whether the completing data phase overlaps the
// tracked address, keeps the last written byte, and compares reads against it.
module ahbl_scoreboard_slot
   import ahbl_pkg::*;
#(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [W_ADDR-1:0] addr,
   input  logic              xfer_done,   // tracked data phase completing now
   input  logic              xfer_write,
   input  logic              xfer_err,    // completing with hresp=1
   input  logic [W_ADDR-1:0] dph_addr,
   input  logic [2:0]        dph_size,
   input  logic [W_DATA-1:0] hwdata,
   input  logic [W_DATA-1:0] hrdata,
   output slot_state_t       state,
   output logic              cmp_valid,
   output logic              cmp_mismatch
);
   localparam int LANE_W = $clog2(W_DATA / 8);

   slot_state_t       state_d;
   logic [7:0]        byte_q;
   logic [7:0]        byte_d;
   logic [W_ADDR-1:0] addr_q;
   logic [W_ADDR:0]   lo;
   logic [W_ADDR:0]   hi;
   logic [W_ADDR:0]   tgt;
   logic              hit;
   logic              addr_chg;
   logic [LANE_W-1:0] lane;
   logic [7:0]        wr_byte;
   logic [7:0]        rd_byte;

   // One extra bit so a transfer ending at the top of the address space
   // does not wrap and miss.
   assign lo       = {1'b0, dph_addr};
   assign hi       = lo + ((W_ADDR + 1)'(1) << dph_size);
   assign tgt      = {1'b0, addr};
   assign hit      = en && (lo <= tgt) && (hi > tgt);
   assign addr_chg = (addr != addr_q);
   assign lane     = addr[LANE_W-1:0];
   assign wr_byte  = hwdata[{lane, 3'b000} +: 8];
   assign rd_byte  = hrdata[{lane, 3'b000} +: 8];

   // Previous tracked address, to notice retargeting of the slot.
   always_ff @(posedge clk) begin
      addr_q <= addr;
   end

   // Slot state and captured byte register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SLOT_EMPTY;
         byte_q <= '0;
      end else begin
         state  <= state_d;
         byte_q <= byte_d;
      end
   end

   // Next state, byte capture and read comparison; a disabled or retargeted
   // slot forgets its byte and never compares in that cycle.
   always_comb begin
      state_d      = state;
      byte_d       = byte_q;
      cmp_valid    = 1'b0;
      cmp_mismatch = 1'b0;
      if (!en || addr_chg) begin
         state_d = SLOT_EMPTY;
      end else if (xfer_done && hit) begin
         if (xfer_write) begin
            if (xfer_err) begin
               state_d = SLOT_EMPTY;
            end else begin
               state_d = SLOT_VALID;
               byte_d  = wr_byte;
            end
         end else if (!xfer_err && state == SLOT_VALID) begin
            cmp_valid    = 1'b1;
            cmp_mismatch = (rd_byte != byte_q);
         end
      end
   end

endmodule

// File: rtl/ahbl_mem_scoreboard.sv
// Passive AHB-Lite scoreboard: shadows up to N_TRACK bytes of memory, checks
// tracked reads against the last tracked write, and flags protocol faults.
module ahbl_mem_scoreboard
   import ahbl_pkg::*;
#(
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter int N_TRACK = 4,
   localparam int SLOT_W = (N_TRACK > 1) ? $clog2(N_TRACK) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   ahbl_mem_scoreboard_if.monitor    bus,
   input  logic [N_TRACK-1:0]        trk_en,
   input  logic [N_TRACK*W_ADDR-1:0] trk_addr,
   output logic                      err_data,
   output logic                      err_proto,
   output logic [SLOT_W-1:0]         err_slot,
   output logic [15:0]               check_cnt,
   output logic [N_TRACK-1:0]        dbg_slot_valid
);
   localparam int AP_W = 2 + 1 + 3 + 3 + 4 + W_ADDR;

   logic              dph_active;
   logic              dph_write;
   logic              dph_tracked;
   logic [W_ADDR-1:0] dph_addr;
   logic [2:0]        dph_size;

   logic              wait_err_q;  // previous cycle was first ERROR cycle
   logic              pend_q;      // previous cycle stalled a live request
   logic [AP_W-1:0]   ap_q;
   logic [AP_W-1:0]   ap_now;
   logic              proto_fail;
   logic              xfer_done;

   slot_state_t       slot_state [N_TRACK];
   logic [N_TRACK-1:0] cmp_valid;
   logic [N_TRACK-1:0] mismatch;
   logic [SLOT_W-1:0]  first_slot;

   assign ap_now    = {bus.htrans, bus.hwrite, bus.hsize, bus.hburst,
                       bus.hprot, bus.haddr};
   assign xfer_done = dph_active && dph_tracked && bus.hready;

   // Data-phase register: the address phase moves into the data phase on hready.
   always_ff @(posedge clk) begin
      if (rst) begin
         dph_active  <= 1'b0;
         dph_write   <= 1'b0;
         dph_tracked <= 1'b0;
         dph_addr    <= '0;
         dph_size    <= '0;
      end else if (bus.hready) begin
         dph_active  <= bus.htrans[1];
         dph_write   <= bus.hwrite;
         dph_tracked <= prot_tracked(bus.hprot);
         dph_addr    <= bus.haddr;
         dph_size    <= bus.hsize;
      end
   end

   // Bus history needed by the response and stall-stability rules.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_err_q <= 1'b0;
         pend_q     <= 1'b0;
         ap_q       <= '0;
      end else begin
         wait_err_q <= bus.hresp && !bus.hready;
         pend_q     <= bus.htrans[1] && !bus.hready;
         ap_q       <= ap_now;
      end
   end

   // Protocol rules evaluated on the current bus cycle.
   always_comb begin
      proto_fail = 1'b0;
      if (!dph_active && (!bus.hready || bus.hresp)) proto_fail = 1'b1;
      if (bus.hresp && bus.hready && !wait_err_q)    proto_fail = 1'b1;
      if (wait_err_q && !bus.hresp)                  proto_fail = 1'b1;
      if (pend_q && (ap_now != ap_q))                proto_fail = 1'b1;
   end

   for (genvar i = 0; i < N_TRACK; i++) begin : g_slot
      ahbl_scoreboard_slot #(
         .W_ADDR(W_ADDR),
         .W_DATA(W_DATA)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .en           (trk_en[i]),
         .addr         (trk_addr[i*W_ADDR +: W_ADDR]),
         .xfer_done    (xfer_done),
         .xfer_write   (dph_write),
         .xfer_err     (bus.hresp),
         .dph_addr     (dph_addr),
         .dph_size     (dph_size),
         .hwdata       (bus.hwdata),
         .hrdata       (bus.hrdata),
         .state        (slot_state[i]),
         .cmp_valid    (cmp_valid[i]),
         .cmp_mismatch (mismatch[i])
      );
      assign dbg_slot_valid[i] = (slot_state[i] == SLOT_VALID);
   end

   // Lowest-index mismatching slot wins.
   always_comb begin
      first_slot = '0;
      for (int i = N_TRACK - 1; i >= 0; i--) begin
         if (mismatch[i]) first_slot = SLOT_W'(i);
      end
   end

   // Sticky error flags, frozen error slot and saturating comparison count.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_data  <= 1'b0;
         err_proto <= 1'b0;
         err_slot  <= '0;
         check_cnt <= '0;
      end else begin
         if ((|cmp_valid) && (check_cnt != 16'hffff)) check_cnt <= check_cnt + 16'd1;
         if (!err_data && (|mismatch)) begin
            err_data <= 1'b1;
            err_slot <= first_slot;
         end
         if (proto_fail) err_proto <= 1'b1;
      end
   end

endmodule

// File: doc/ahbl_mem_scoreboard.md
AHBL_MEM_SCOREBOARD -- requirements
Module: ahbl_mem_scoreboard

Interface
REQ-001 W_ADDR, 32: address width.
REQ-002 W_DATA, 32: data width, 32 or 64.
REQ-003 N_TRACK, 4: number of independently tracked bytes, 1..16.
REQ-004 clk  in  1: single clock; all state on rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 hready, hresp, hwrite  in  1 each: observed AHB-Lite bus, read-only tap.
REQ-007 htrans  in  2: observed bus transfer type.
REQ-008 hsize, hburst  in  3 each: observed bus size and burst.
REQ-009 hprot  in  4: observed bus protection attributes.
REQ-010 haddr  in  W_ADDR: observed bus address.
REQ-011 hwdata, hrdata  in  W_DATA each: observed bus data.
REQ-012 trk_en  in  N_TRACK: per-slot enable.
REQ-013 trk_addr  in  N_TRACK*W_ADDR: per-slot byte address, packed; slot i at [i*W_ADDR +: W_ADDR].
REQ-014 err_data  out  1: sticky; a tracked read returned a stale or wrong byte.
REQ-015 err_proto  out  1: sticky; AHB-Lite response or request rule violated.
REQ-016 err_slot  out  $clog2(N_TRACK) (min 1): lowest slot index of the first data error.
REQ-017 check_cnt  out  16: count of completed tracked-read comparisons, saturating.

Function
REQ-018 Data-phase register: on hready, capture htrans[1], hwrite, haddr, hsize, hprot; a transfer completes on a cycle with hready=1 and active data phase.
REQ-019 Overlap: slot i is hit when trk_en[i], dph_addr <= trk_addr[i], and dph_addr + (1<<dph_size) > trk_addr[i]; the byte lane is trk_addr[i] mod (W_DATA/8).
REQ-020 Per-slot FSM: EMPTY -> VALID on a completed OKAY write hit, capturing hwdata[lane]; VALID -> VALID on a further write hit, recapturing the byte; any state -> EMPTY on a write hit completing with hresp=1.
REQ-021 Read hit completing with OKAY in VALID: compare hrdata[lane] against the stored byte; mismatch sets err_data; check_cnt increments once per comparison, not once per slot.
REQ-022 Read hit in EMPTY: no comparison, no count.
REQ-023 trk_en[i] low, or trk_addr[i] changing, forces slot i to EMPTY the following cycle.
REQ-024 Multiple slots mismatching in one cycle: err_slot takes the lowest index; err_slot is frozen once err_data is set.
REQ-025 Protocol checks, any failure sets err_proto: hready=0 or hresp=1 during an idle data phase; hresp=1 with hready=1 not preceded by hresp=1 with hready=0; hresp=1 with hready=0 not followed by hresp=1; address-phase signals changing while htrans[1] is pending and hready=0.
REQ-026 Only hprot[3:2]==2'b11 transfers update or check slots; other transfers pass untracked.
REQ-027 Latency: err_data, err_proto and check_cnt update one cycle after the offending or completing bus cycle.
REQ-028 check_cnt saturates at 16'hffff.

Reset
REQ-029 On rst: all slots EMPTY, data-phase register idle, err_data=0, err_proto=0, err_slot=0, check_cnt=0.
REQ-030 Reset mid-transfer discards the in-flight data phase; no check or error arises from it.

Structure
REQ-031 Shared package ahbl_pkg holds the HTRANS encodings (IDLE, BUSY, NSEQ, SEQ) and the HPROT cacheable/bufferable bit positions.
REQ-032 One sub-module, ahbl_scoreboard_slot, holds one slot's FSM, captured byte and compare logic, instantiated N_TRACK times; the top holds the data-phase register, protocol checks, priority encode and counter.

Verification
REQ-033 Slot0 at 0x13: write byte 0x5A to 0x13, hsize=0; read word 0x10 with hrdata[31:24]=0x5A -> check_cnt=1, err_data=0.
REQ-034 Same write, then read returns 0xA5 in lane 3 -> err_data=1 and err_slot=0 one cycle after the read completes.
REQ-035 Slots 1 and 2 both hit by a word write, then a word read corrupting both lanes -> err_slot=1, check_cnt=1.
REQ-036 Write to 0x13 completing with a two-cycle ERROR response, then read of any value -> slot EMPTY, no compare, err_proto=0.
REQ-037 Single-cycle hresp=1 with hready=1 -> err_proto=1; idle data phase with hready=0 -> err_proto=1.
REQ-038 Slot VALID, trk_en dropped for one cycle and re-raised, then a mismatching read -> no error, check_cnt unchanged.
